// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Encodings shared by the local-road car detector and the
//               traffic light controller: one-hot light codes, the loop
//               debounce state type and a red-light classification helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    localparam logic [2:0] LIGHT_GREEN  = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b001;

    typedef enum logic [1:0] {
        DB_LOW     = 2'd0,
        DB_CONF_HI = 2'd1,
        DB_HIGH    = 2'd2,
        DB_CONF_LO = 2'd3
    } db_state_e;

    // Anything that is not a clean green or yellow is treated as red, so a
    // corrupted light bus can never hide a red-light runner.
    function automatic logic light_is_red(input logic [2:0] light);
        return (light != LIGHT_GREEN) && (light != LIGHT_YELLOW);
    endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/lr_car_detector_loop.sv
`default_nettype none
// ============================================================================
// Module      : loop_debouncer
// Description : Conditioning path for one inductive loop: 2-flop
//               synchronizer, debounce FSM, rising-edge event pulse on the
//               filtered level and a stuck-high detector.
// Ports       : clk      in  clock
//               rst_n    in  synchronous active-low reset
//               loop_i   in  raw asynchronous loop level (1 = metal)
//               ev_o     out registered one-cycle pulse, filtered level rose
//               stuck_o  out filtered level high for more than STUCK_CYC
// Revision    : 1.0 - initial release
// ============================================================================
module loop_debouncer
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE  = 4,
    parameter int STUCK_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic loop_i,
    output logic ev_o,
    output logic stuck_o
);

    localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam int ST_W = $clog2(STUCK_CYC + 2);

    localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE - 1);
    localparam logic [ST_W-1:0] ST_LIMIT = ST_W'(STUCK_CYC);
    localparam logic [ST_W-1:0] ST_MAX   = '1;

    logic              sync1_q;
    logic              sync2_q;
    db_state_e         state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic              ev_q, ev_d;
    logic [ST_W-1:0]   stuck_cnt_q, stuck_cnt_d;
    logic              filt_w;

    assign filt_w = (state_q == DB_HIGH) || (state_q == DB_CONF_LO);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= DB_LOW;
            db_cnt_q    <= '0;
            ev_q        <= 1'b0;
            stuck_cnt_q <= '0;
        end else begin
            sync1_q     <= loop_i;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            ev_q        <= ev_d;
            stuck_cnt_q <= stuck_cnt_d;
        end
    end

    // db_cnt holds how many consecutive confirming samples have been seen;
    // the transition fires on the DEBOUNCE-th one (the entering sample counts).
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        unique case (state_q)
            DB_LOW: begin
                if (sync2_q) begin
                    if (DEBOUNCE == 1) begin
                        state_d = DB_HIGH;
                    end else begin
                        state_d  = DB_CONF_HI;
                        db_cnt_d = DB_W'(1);
                    end
                end
            end
            DB_CONF_HI: begin
                if (!sync2_q) begin
                    state_d  = DB_LOW;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = DB_HIGH;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            DB_HIGH: begin
                if (!sync2_q) begin
                    if (DEBOUNCE == 1) begin
                        state_d = DB_LOW;
                    end else begin
                        state_d  = DB_CONF_LO;
                        db_cnt_d = DB_W'(1);
                    end
                end
            end
            DB_CONF_LO: begin
                if (sync2_q) begin
                    state_d  = DB_HIGH;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d  = DB_LOW;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: begin
                state_d  = DB_LOW;
                db_cnt_d = '0;
            end
        endcase
    end

    // Event only when filtered goes 0->1; CONF_LO->HIGH is a recovered
    // glitch on an already-present vehicle and must not count again.
    assign ev_d = (state_d == DB_HIGH) && !filt_w;

    // Saturating counter: all-ones is above STUCK_CYC, so the fault
    // condition persists for as long as the loop stays high.
    always_comb begin
        stuck_cnt_d = '0;
        if (filt_w) begin
            stuck_cnt_d = (stuck_cnt_q == ST_MAX) ? ST_MAX : stuck_cnt_q + ST_W'(1);
        end
    end

    assign ev_o    = ev_q;
    assign stuck_o = (stuck_cnt_q > ST_LIMIT);

endmodule : loop_debouncer
`default_nettype wire

// File: rtl/lr_car_detector.sv
`default_nettype none
// ============================================================================
// Module      : lr_car_detector
// Description : Local-road vehicle presence front end. Counts vehicles
//               between the arrival and stop-line loops, flags red-light
//               runners and forces lr_has_car when a loop is stuck high.
// Ports       : clk          in  clock
//               rst_n        in  synchronous active-low reset
//               arr_loop     in  raw arrival loop
//               dep_loop     in  raw stop-line loop
//               lr_light     in  [2:0] one-hot light, [2]=G [1]=Y [0]=R
//               lr_has_car   out queue non-empty or sensor fault
//               queue_cnt    out [CNT_W-1:0] saturating vehicle count
//               queue_full   out queue_cnt at maximum
//               red_run      out pulse, departure while light is red
//               sensor_fault out sticky stuck-loop flag
// Revision    : 1.0 - initial release
// ============================================================================
module lr_car_detector
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE  = 4,
    parameter int CNT_W     = 4,
    parameter int STUCK_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             arr_loop,
    input  logic             dep_loop,
    input  logic [2:0]       lr_light,
    output logic             lr_has_car,
    output logic [CNT_W-1:0] queue_cnt,
    output logic             queue_full,
    output logic             red_run,
    output logic             sensor_fault
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             arr_ev, dep_ev;
    logic             arr_stuck, dep_stuck;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             has_car_q, has_car_d;
    logic             full_q, full_d;
    logic             red_run_q, red_run_d;
    logic             fault_q, fault_d;

    loop_debouncer #(
        .DEBOUNCE  (DEBOUNCE),
        .STUCK_CYC (STUCK_CYC)
    ) u_arr_loop (
        .clk     (clk),
        .rst_n   (rst_n),
        .loop_i  (arr_loop),
        .ev_o    (arr_ev),
        .stuck_o (arr_stuck)
    );

    loop_debouncer #(
        .DEBOUNCE  (DEBOUNCE),
        .STUCK_CYC (STUCK_CYC)
    ) u_dep_loop (
        .clk     (clk),
        .rst_n   (rst_n),
        .loop_i  (dep_loop),
        .ev_o    (dep_ev),
        .stuck_o (dep_stuck)
    );

    // A simultaneous arrival and departure cancel out, which also keeps the
    // count stable at both the saturation and the empty boundaries.
    always_comb begin
        cnt_d = cnt_q;
        if (arr_ev && !dep_ev && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (dep_ev && !arr_ev && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    assign fault_d   = fault_q | arr_stuck | dep_stuck;
    assign red_run_d = dep_ev & light_is_red(lr_light);
    assign full_d    = (cnt_d == CNT_MAX);
    assign has_car_d = (cnt_d != '0) | fault_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            has_car_q <= 1'b0;
            full_q    <= 1'b0;
            red_run_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            has_car_q <= has_car_d;
            full_q    <= full_d;
            red_run_q <= red_run_d;
            fault_q   <= fault_d;
        end
    end

    assign queue_cnt    = cnt_q;
    assign lr_has_car   = has_car_q;
    assign queue_full   = full_q;
    assign red_run      = red_run_q;
    assign sensor_fault = fault_q;

endmodule : lr_car_detector
`default_nettype wire

// File: tb/tb_lr_car_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_lr_car_detector
// Description : Self-checking bench for lr_car_detector. A behavioural model
//               (loop level accepted after DEBOUNCE identical samples,
//               integer queue arithmetic) predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lr_car_detector;

    localparam int DEBOUNCE  = 4;
    localparam int CNT_W     = 4;
    localparam int STUCK_CYC = 255;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             arr_loop = 1'b0;
    logic             dep_loop = 1'b0;
    logic [2:0]       lr_light = 3'b100;
    logic             lr_has_car;
    logic [CNT_W-1:0] queue_cnt;
    logic             queue_full;
    logic             red_run;
    logic             sensor_fault;

    lr_car_detector #(
        .DEBOUNCE  (DEBOUNCE),
        .CNT_W     (CNT_W),
        .STUCK_CYC (STUCK_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arr_loop     (arr_loop),
        .dep_loop     (dep_loop),
        .lr_light     (lr_light),
        .lr_has_car   (lr_has_car),
        .queue_cnt    (queue_cnt),
        .queue_full   (queue_full),
        .red_run      (red_run),
        .sensor_fault (sensor_fault)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // ---------------- behavioural model ----------------
    int                  m_cnt;
    bit                  m_has, m_full, m_red, m_fault;
    bit                  s1[2], s2[2], filt[2], ev[2];
    int                  hi[2];
    logic [DEBOUNCE-1:0] hv[2];
    int                  hn[2];

    wire [7:0] obs = {lr_has_car, queue_cnt, queue_full, red_run, sensor_fault};

    function automatic logic [7:0] expv();
        return {m_has, CNT_W'(m_cnt), m_full, m_red, m_fault};
    endfunction

    // A loop's filtered level takes a new value once the last DEBOUNCE
    // synchronized samples all agree on it.
    function automatic void loop_step(int l, bit raw);
        bit seen, nf;
        seen  = s2[l];
        s2[l] = s1[l];
        s1[l] = raw;
        hv[l] = {hv[l][DEBOUNCE-2:0], seen};
        if (hn[l] < DEBOUNCE) hn[l]++;
        hi[l] = filt[l] ? hi[l] + 1 : 0;
        nf = filt[l];
        if (hn[l] == DEBOUNCE) begin
            if (hv[l] == '1) nf = 1'b1;
            if (hv[l] == '0) nf = 1'b0;
        end
        ev[l]   = nf && !filt[l];
        filt[l] = nf;
    endfunction

    function automatic void model_step();
        bit a, d, stuck;
        if (!rst_n) begin
            m_cnt = 0; m_has = 0; m_full = 0; m_red = 0; m_fault = 0;
            for (int l = 0; l < 2; l++) begin
                s1[l] = 0; s2[l] = 0; filt[l] = 0; ev[l] = 0;
                hi[l] = 0; hv[l] = '0; hn[l] = 0;
            end
            return;
        end
        a     = ev[0];
        d     = ev[1];
        stuck = (hi[0] > STUCK_CYC) || (hi[1] > STUCK_CYC);
        if (a && !d)      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
        else if (d && !a) m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
        m_red   = d && (lr_light != 3'b100) && (lr_light != 3'b010);
        m_fault = m_fault || stuck;
        m_full  = (m_cnt == CNT_MAX);
        m_has   = (m_cnt != 0) || m_fault;
        loop_step(0, arr_loop);
        loop_step(1, dep_loop);
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    // ---------------- stimulus schedule ----------------
    bit         sa[$], sd[$];
    logic [2:0] sl[$];

    task automatic clear_sched();
        sa.delete(); sd.delete(); sl.delete();
    endtask

    // lt < 0 selects a random (possibly invalid) light each cycle.
    task automatic push(bit a, bit d, int n, int lt);
        repeat (n) begin
            sa.push_back(a);
            sd.push_back(d);
            sl.push_back((lt < 0) ? 3'($urandom_range(0, 7)) : 3'(lt));
        end
    endtask

    task automatic push_car(bit a, bit d, int lt);
        push(a, d, 6, lt);
        push(0, 0, 6, lt);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            arr_loop = 1'($urandom_range(0, 1));
            dep_loop = ~arr_loop;
            lr_light = 3'($urandom_range(0, 7));
            cycle();
            vectors++;
            if (obs !== 8'h00) begin
                miscompares++;
                $display("FAIL reset cyc=%0d got=%b exp=%b", cyc, obs, 8'h00);
            end
        end
        rst_n = 1'b1; arr_loop = 1'b0; dep_loop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            vectors++;
            if (obs !== 8'h00 || obs !== expv()) begin
                miscompares++;
                $display("FAIL post_reset cyc=%0d got=%b exp=%b", cyc, obs, 8'h00);
            end
        end
    endtask

    task automatic test_single_car();
        bit red_seen = 0;
        clear_sched();
        push(1, 0, 10, 3'b100); push(0, 0, 8, 3'b100);
        push(0, 1, 10, 3'b100); push(0, 0, 10, 3'b100);
        for (int i = 0; i < sa.size(); i++) begin
            arr_loop = sa[i]; dep_loop = sd[i]; lr_light = sl[i];
            cycle();
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL single_car cyc=%0d got=%b exp=%b", cyc, obs, expv());
            end
            red_seen |= red_run;
            if (i == 5) begin
                vectors++;
                if (queue_cnt !== 4'd0) begin
                    miscompares++;
                    $display("FAIL single_car_early cnt=%0d exp=0", queue_cnt);
                end
            end
            if (i == 6) begin
                vectors++;
                if (queue_cnt !== 4'd1 || lr_has_car !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_car_latency cnt=%0d has=%b exp=1/1", queue_cnt, lr_has_car);
                end
            end
        end
        vectors++;
        if (queue_cnt !== 4'd0 || lr_has_car !== 1'b0 || red_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL single_car_depart cnt=%0d has=%b red=%b exp=0/0/0", queue_cnt, lr_has_car, red_seen);
        end
    endtask

    task automatic test_glitch();
        int n_pulse, p;
        clear_sched();
        push(1, 0, DEBOUNCE - 1, -1); push(0, 0, 7, -1);
        for (int k = 0; k < 5; k++) begin
            push(1, 0, $urandom_range(1, DEBOUNCE - 1), -1);
            push(0, 0, $urandom_range(DEBOUNCE + 2, 9), -1);
        end
        n_pulse = sa.size();
        p = $urandom_range(2, 17);
        push(1, 0, p, -1); push(0, 0, 1, -1); push(1, 0, 19 - p, -1); push(0, 0, 10, -1);
        for (int i = 0; i < sa.size(); i++) begin
            arr_loop = sa[i]; dep_loop = sd[i]; lr_light = sl[i];
            cycle();
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL glitch cyc=%0d got=%b exp=%b", cyc, obs, expv());
            end
            if (i == n_pulse - 1) begin
                vectors++;
                if (queue_cnt !== 4'd0) begin
                    miscompares++;
                    $display("FAIL glitch_reject cnt=%0d exp=0", queue_cnt);
                end
            end
        end
        vectors++;
        if (queue_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL glitch_dropout cnt=%0d exp=1", queue_cnt);
        end
    endtask

    task automatic test_saturation();
        int n_arr;
        clear_sched();
        repeat (17) push_car(1, 0, -1);
        n_arr = sa.size();
        repeat (16) push_car(0, 1, -1);
        for (int i = 0; i < sa.size(); i++) begin
            arr_loop = sa[i]; dep_loop = sd[i]; lr_light = sl[i];
            cycle();
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL saturation cyc=%0d got=%b exp=%b", cyc, obs, expv());
            end
            if (i == n_arr - 1) begin
                vectors++;
                if (queue_cnt !== 4'd15 || queue_full !== 1'b1) begin
                    miscompares++;
                    $display("FAIL saturate cnt=%0d full=%b exp=15/1", queue_cnt, queue_full);
                end
            end
        end
        vectors++;
        if (queue_cnt !== 4'd0 || queue_full !== 1'b0) begin
            miscompares++;
            $display("FAIL floor cnt=%0d full=%b exp=0/0", queue_cnt, queue_full);
        end
    endtask

    task automatic test_simultaneous();
        int m3, m15;
        clear_sched();
        repeat (3) push_car(1, 0, -1);
        push(1, 1, 8, -1); push(0, 0, 8, -1);
        m3 = sa.size();
        repeat (12) push_car(1, 0, -1);
        push(1, 1, 8, -1); push(0, 0, 8, -1);
        m15 = sa.size();
        repeat (15) push_car(0, 1, -1);
        push(1, 1, 8, -1); push(0, 0, 8, -1);
        for (int i = 0; i < sa.size(); i++) begin
            arr_loop = sa[i]; dep_loop = sd[i]; lr_light = sl[i];
            cycle();
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL simultaneous cyc=%0d got=%b exp=%b", cyc, obs, expv());
            end
            if (i == m3 - 1) begin
                vectors++;
                if (queue_cnt !== 4'd3) begin
                    miscompares++;
                    $display("FAIL simul_mid cnt=%0d exp=3", queue_cnt);
                end
            end
            if (i == m15 - 1) begin
                vectors++;
                if (queue_cnt !== 4'd15 || queue_full !== 1'b1) begin
                    miscompares++;
                    $display("FAIL simul_full cnt=%0d full=%b exp=15/1", queue_cnt, queue_full);
                end
            end
        end
        vectors++;
        if (queue_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL simul_empty cnt=%0d exp=0", queue_cnt);
        end
    endtask

    task automatic test_red_run_fault();
        int red_cycles = 0;
        int s;
        clear_sched();
        push_car(1, 0, 3'b100);
        push(0, 1, 6, 3'b001); push(0, 0, 8, 3'b001);
        s = sa.size();
        push(1, 0, 300, -1); push(0, 0, 10, -1);
        push_car(0, 1, 3'b100); push(0, 0, 6, 3'b100);
        for (int i = 0; i < sa.size(); i++) begin
            arr_loop = sa[i]; dep_loop = sd[i]; lr_light = sl[i];
            cycle();
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL red_fault cyc=%0d got=%b exp=%b", cyc, obs, expv());
            end
            if (i < s && red_run === 1'b1) red_cycles++;
            if (i == s - 1) begin
                vectors++;
                if (red_cycles !== 1 || queue_cnt !== 4'd0) begin
                    miscompares++;
                    $display("FAIL red_run pulses=%0d cnt=%0d exp=1/0", red_cycles, queue_cnt);
                end
            end
            if (i == s + 261) begin
                vectors++;
                if (sensor_fault !== 1'b0) begin
                    miscompares++;
                    $display("FAIL fault_early fault=%b exp=0", sensor_fault);
                end
            end
            if (i == s + 262) begin
                vectors++;
                if (sensor_fault !== 1'b1) begin
                    miscompares++;
                    $display("FAIL fault_set fault=%b exp=1", sensor_fault);
                end
            end
        end
        vectors++;
        if (sensor_fault !== 1'b1 || lr_has_car !== 1'b1 || queue_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL fault_hold fault=%b has=%b cnt=%0d exp=1/1/0", sensor_fault, lr_has_car, queue_cnt);
        end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            vectors++;
            if (obs !== 8'h00) begin
                miscompares++;
                $display("FAIL fault_clear cyc=%0d got=%b exp=%b", cyc, obs, 8'h00);
            end
        end
    endtask

    task automatic test_back_to_back();
        int rst_at;
        clear_sched();
        for (int k = 0; k < 60; k++) begin
            push(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12), -1);
        end
        rst_at = $urandom_range(150, sa.size() - 40);
        for (int i = 0; i < sa.size(); i++) begin
            arr_loop = sa[i]; dep_loop = sd[i]; lr_light = sl[i];
            rst_n = (i != rst_at);
            cycle();
            vectors++;
            if (obs !== expv()) begin
                miscompares++;
                $display("FAIL back_to_back cyc=%0d got=%b exp=%b", cyc, obs, expv());
            end
            if (i == rst_at) begin
                vectors++;
                if (obs !== 8'h00) begin
                    miscompares++;
                    $display("FAIL mid_reset got=%b exp=%b", obs, 8'h00);
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_car();
        test_glitch();
        test_saturation();
        test_simultaneous();
        test_red_run_fault();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_lr_car_detector
`default_nettype wire
